mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter MAX_LEN, 16, maximum dot-product length and operand buffer depth (fixed; not overridable).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_len  input  5  dot-product length N, 0..31.
REQ-006 cmd_ready  output  1  high only in IDLE.
REQ-007 in_valid  input  1  operand pair valid.
REQ-008 in_a / in_b  input  8 each  unsigned operand pair.
REQ-009 in_ready  output  1  high only in LOAD.
REQ-010 res_valid  output  1  result valid.
REQ-011 res_data  output  16  dot-product result.
REQ-012 res_err  output  1  set when mac_valid was low at capture.
REQ-013 res_ready  input  1  result accept.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 mac_en / mac_a / mac_b  output  1/8/8  drive the MAC enable and operand ports.
REQ-016 mac_c / mac_valid  input  16/1  MAC registered result and valid; the MAC shares clk and reset_n.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN, DRAIN, CAPT, DONE; state changes only on clk rising edge.
REQ-018 IDLE: command accepted on an edge with cmd_valid&cmd_ready; latch N = min(cmd_len,16).
REQ-019 N=0: IDLE->DONE directly, res_data=0, res_err=0, mac_en never asserted.
REQ-020 N>=1: IDLE->LOAD, write index cleared.
REQ-021 LOAD: each edge with in_valid&in_ready writes {in_a,in_b} to buffer[idx], idx+1; after the Nth write, ->RUN; in_valid low simply waits (no timeout).
REQ-022 RUN: exactly N consecutive cycles, mac_en=1, mac_a/mac_b=buffer[i] for i=0..N-1 in order; no stall permitted.
REQ-023 DRAIN: exactly 2 cycles, mac_en=1, mac_a=mac_b=0 (flushes MAC input registers to zero so the next run starts clean).
REQ-024 CAPT: 1 cycle, mac_en=0; on its edge res_data<=mac_c, res_err<=~mac_valid, ->DONE.
REQ-025 DONE: res_valid=1, res_data/res_err held stable until an edge with res_ready=1, then ->IDLE.
REQ-026 Latency: res_valid rises exactly N+3 edges after the edge accepting the Nth operand.
REQ-027 Arithmetic: result = sum of a_i*b_i modulo 2^16 (unsigned wrap, no saturation, no overflow flag).
REQ-028 Outside RUN/DRAIN, mac_en=0 and mac_a=mac_b=0.
REQ-029 cmd_valid outside IDLE and in_valid outside LOAD are ignored; no side effect.
REQ-030 res_ready high in DONE on the same edge as a new cmd_valid: command not accepted that edge (cmd_ready low in DONE); accepted no earlier than the next edge.
REQ-031 Back-to-back commands SHALL produce correct results, with no carry-over from the previous run.

Reset
REQ-032 On an edge with reset_n=0, from any state (including mid-LOAD/RUN/DRAIN): state=IDLE, idx=0, N=0.
REQ-033 During and after reset, outputs SHALL be: res_valid=0, res_data=0, res_err=0, busy=0, mac_en=0, mac_a=mac_b=0, in_ready=0.
REQ-034 cmd_ready=1 on the first cycle after reset_n returns high.
REQ-035 Buffer contents need not be reset; they are never read before being written.

Verification
REQ-036 N=1, pair (3,4) -> res_data=12, res_err=0, res_valid exactly 4 edges after operand accept.
REQ-037 N=4, pairs (1,2),(3,4),(5,6),(7,8) with in_valid gaps of 0-3 cycles -> res_data=100; mac_en high exactly 6 consecutive cycles.
REQ-038 N=2, pairs (255,255)x2 -> res_data=0xFC02 (wrap); then N=1 (2,2) -> res_data=4, proving no carry-over.
REQ-039 res_ready held low 5 cycles in DONE -> res_data stable, cmd_ready=0, busy=1; accepted on the 6th edge.
REQ-040 cmd_len=0 -> res_valid next cycle with res_data=0, mac_en never high; cmd_len=20 -> exactly 16 operands accepted.
REQ-041 reset_n low for 1 edge mid-RUN -> all outputs at reset values; the next N=1 (5,6) command returns 30.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for an external registered MAC: buffers N operand pairs, streams them
// into the MAC back-to-back, flushes its input registers with zeros, then captures the sum.
module mac_seq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [4:0]  cmd_len,
  output logic        cmd_ready,
  input  logic        in_valid,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        in_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_err,
  input  logic        res_ready,
  output logic        busy,
  output logic        mac_en,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  input  logic [15:0] mac_c,
  input  logic        mac_valid
);

  localparam int MAX_LEN = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_CAPT, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  n_q, n_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        buf_we;
  logic [15:0] buf_q [MAX_LEN];

  function automatic logic [4:0] sat_len(input logic [4:0] len);
    return (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // Operand storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[3:0]] <= {in_a, in_b};
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    buf_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          n_d   = sat_len(cmd_len);
          idx_d = '0;
          if (sat_len(cmd_len) == 5'd0) begin
            state_d    = S_DONE;
            res_data_d = '0;
            res_err_d  = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (idx_q == n_q - 5'd1) begin
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_RUN: begin
        if (idx_q == n_q - 5'd1) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_DRAIN: begin
        if (idx_q == 5'd1) begin
          idx_d   = '0;
          state_d = S_CAPT;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_CAPT: begin
        res_data_d = mac_c;
        res_err_d  = ~mac_valid;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD:  in_ready = 1'b1;
      S_RUN: begin
        mac_en = 1'b1;
        mac_a  = buf_q[idx_q[3:0]][15:8];
        mac_b  = buf_q[idx_q[3:0]][7:0];
      end
      S_DRAIN: mac_en = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data = res_data_q;
  assign res_err  = res_err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a registered accumulate MAC sits on the mac_* ports and
// every command is scored against a plain sum-of-products reference.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_len = '0;
  logic        cmd_ready;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        mac_en;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [15:0] mac_c;
  logic        mac_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_ready (res_ready),
    .busy      (busy),
    .mac_en    (mac_en),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_valid (mac_valid)
  );

  // Registered MAC: input registers, then an accumulator cleared whenever idle.
  logic [7:0]  ma_q = '0, mb_q = '0;
  logic        men_q = 1'b0, mvalid_q = 1'b0;
  logic [15:0] acc_q = '0;
  logic        mac_bad = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      ma_q <= '0; mb_q <= '0; men_q <= 1'b0; acc_q <= '0; mvalid_q <= 1'b0;
    end else begin
      ma_q     <= mac_a;
      mb_q     <= mac_b;
      men_q    <= mac_en;
      acc_q    <= men_q ? acc_q + 16'(ma_q) * 16'(mb_q) : 16'd0;
      mvalid_q <= men_q & ~mac_bad;
    end
  end
  assign mac_c     = acc_q;
  assign mac_valid = mvalid_q;

  // Observer of the MAC port: enable cycles, operand order, idle leakage.
  int          cyc = 0, en_cnt = 0, en_first = 0, en_last = 0, leak = 0, mon_n = 0;
  logic        en_prev = 1'b0;
  logic [15:0] mon_arr [256];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_prev <= mac_en;
    if (mac_en) begin
      en_cnt  <= en_cnt + 1;
      en_last <= cyc;
      if (!en_prev) en_first <= cyc;
      mon_arr[mon_n % 256] <= {mac_a, mac_b};
      mon_n <= mon_n + 1;
    end else if (mac_a != 8'd0 || mac_b != 8'd0) begin
      leak <= leak + 1;
    end
  end

  logic [7:0] opa [32];
  logic [7:0] opb [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string tag, input int len, input int gapmax,
                         input int hold, input bit fixed);
    int          n, lat, s_en, s_mon, gap;
    logic [15:0] exp_sum;
    bit          ord_ok;
    n = (len > 16) ? 16 : len;
    if (!fixed) begin
      for (int i = 0; i < 32; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
    end
    exp_sum = '0;
    for (int i = 0; i < n; i++) exp_sum = exp_sum + 16'(opa[i]) * 16'(opb[i]);

    lat = 0;
    while (cmd_ready !== 1'b1 && lat < 50) begin step(); lat++; end
    chk({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    s_en  = en_cnt;
    s_mon = mon_n;

    cmd_valid = 1'b1;
    cmd_len   = 5'(len);
    step();
    cmd_valid = 1'b0;

    if (n > 0) begin
      chk({tag, ".load_flags"}, {29'd0, busy, in_ready, cmd_ready}, 32'b110);
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(0, gapmax);
        repeat (gap) begin
          in_valid = 1'b0;
          in_a = 8'($urandom);
          in_b = 8'($urandom);
          step();
        end
        in_valid = 1'b1;
        in_a = opa[k];
        in_b = opb[k];
        step();
      end
      in_valid = (len > 16);
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      if (len > 16) chk({tag, ".full_no_ready"}, 32'(in_ready), 32'd0);
    end

    lat = 0;
    while (res_valid !== 1'b1 && lat < 60) begin
      step();
      in_valid = 1'b0;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(lat), (n == 0) ? 32'd0 : 32'(n + 3));
    chk({tag, ".data"}, 32'(res_data), 32'(exp_sum));
    chk({tag, ".err"}, 32'(res_err), 32'(mac_bad));
    chk({tag, ".mac_en_cycles"}, 32'(en_cnt - s_en), (n == 0) ? 32'd0 : 32'(n + 2));
    if (n > 0) begin
      chk({tag, ".mac_en_span"}, 32'(en_last - en_first + 1), 32'(n + 2));
      ord_ok = 1'b1;
      for (int i = 0; i < n; i++)
        if (mon_arr[(s_mon + i) % 256] !== {opa[i], opb[i]}) ord_ok = 1'b0;
      for (int i = n; i < n + 2; i++)
        if (mon_arr[(s_mon + i) % 256] !== 16'd0) ord_ok = 1'b0;
      chk({tag, ".operand_order"}, 32'(ord_ok), 32'd1);
    end

    // A command offered during DONE must not be taken, even on the release edge.
    cmd_valid = 1'b1;
    cmd_len   = 5'd3;
    repeat (hold) begin
      step();
      chk({tag, ".hold_flags"}, {29'd0, res_valid, cmd_ready, busy}, 32'b101);
      chk({tag, ".hold_data"}, 32'(res_data), 32'(exp_sum));
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, ".release"}, {29'd0, res_valid, cmd_ready, busy}, 32'b010);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    chk("reset.outs", {26'd0, res_valid, res_err, busy, mac_en, in_ready, 1'b0},
        32'd0);
    chk("reset.data", {res_data, mac_a, mac_b}, 32'd0);
    reset_n = 1'b1;
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    step();

    opa[0] = 8'd3; opb[0] = 8'd4;
    run_cmd("n1_3x4", 1, 0, 0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'(2 * i + 1);
      opb[i] = 8'(2 * i + 2);
    end
    run_cmd("n4_gaps", 4, 3, 1, 1'b1);

    opa[0] = 8'd255; opb[0] = 8'd255; opa[1] = 8'd255; opb[1] = 8'd255;
    run_cmd("n2_wrap", 2, 0, 0, 1'b1);
    opa[0] = 8'd2; opb[0] = 8'd2;
    run_cmd("n1_after_wrap", 1, 0, 0, 1'b1);

    run_cmd("hold5", 3, 1, 5, 1'b0);
    run_cmd("len0", 0, 0, 1, 1'b0);
    run_cmd("len20", 20, 1, 0, 1'b0);

    mac_bad = 1'b1;
    run_cmd("mac_invalid", 3, 0, 0, 1'b0);
    mac_bad = 1'b0;

    for (int r = 0; r < 10; r++)
      run_cmd("random", $urandom_range(0, 31), 2, $urandom_range(0, 3), 1'b0);

    // Reset in the middle of a run, then a clean command.
    cmd_valid = 1'b1;
    cmd_len   = 5'd4;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("midrun.mac_en", 32'(mac_en), 32'd1);
    reset_n = 1'b0;
    step();
    chk("midrun.reset_outs", {27'd0, res_valid, res_err, busy, mac_en, in_ready}, 32'd0);
    chk("midrun.reset_data", {res_data, mac_a, mac_b}, 32'd0);
    reset_n = 1'b1;
    chk("midrun.cmd_ready", 32'(cmd_ready), 32'd1);
    opa[0] = 8'd5; opb[0] = 8'd6;
    run_cmd("after_reset_5x6", 1, 0, 0, 1'b1);

    chk("idle_mac_leak", 32'(leak), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
